// File: rtl/usb_utmi_pkg.sv
// Shared UTMI types plus line-state controller state encoding and
// default 60 MHz detection timings.
package usb_utmi_pkg;

  typedef enum logic [1:0] {
    UTMI_LS_SE0 = 2'b00,
    UTMI_LS_J   = 2'b01,
    UTMI_LS_K   = 2'b10,
    UTMI_LS_SE1 = 2'b11
  } utmi_line_state_t;

  typedef enum logic [1:0] {
    UTMI_OM_NORMAL  = 2'b00,
    UTMI_OM_NONDRV  = 2'b01,
    UTMI_OM_DISABLE = 2'b10,
    UTMI_OM_RSVD    = 2'b11
  } utmi_op_mode_t;

  typedef enum logic [2:0] {
    LC_NORMAL     = 3'd0,
    LC_BUS_RESET  = 3'd1,
    LC_SUSPEND    = 3'd2,
    LC_WAKE_DRIVE = 3'd3,
    LC_RESUME     = 3'd4
  } usb_linectl_state_t;

  // Line class tracked in NORMAL so a change of class restarts the run count.
  typedef enum logic [1:0] {
    LC_CLS_NONE = 2'd0,
    LC_CLS_SE0  = 2'd1,
    LC_CLS_IDLE = 2'd2
  } usb_linectl_cls_t;

  localparam int unsigned LC_RST_DET_CYC_60M   = 150;
  localparam int unsigned LC_SUSP_DET_CYC_60M  = 180000;
  localparam int unsigned LC_WAKE_HOLD_CYC_60M = 300000;
  localparam int unsigned LC_WAKE_DRV_CYC_60M  = 120000;

  function automatic int unsigned lc_max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/usb_utmi_linectl.sv
// Device-side UTMI line-state controller: bus reset / suspend / resume
// detection and remote-wakeup sequencing, all outputs registered (Moore).
module usb_utmi_linectl
  import usb_utmi_pkg::*;
#(
  parameter int unsigned RST_DET_CYC   = LC_RST_DET_CYC_60M,
  parameter int unsigned SUSP_DET_CYC  = LC_SUSP_DET_CYC_60M,
  parameter int unsigned WAKE_HOLD_CYC = LC_WAKE_HOLD_CYC_60M,
  parameter int unsigned WAKE_DRV_CYC  = LC_WAKE_DRV_CYC_60M,
  parameter int unsigned CNT_W = $clog2(lc_max2(lc_max2(RST_DET_CYC, SUSP_DET_CYC),
                                                lc_max2(WAKE_HOLD_CYC, WAKE_DRV_CYC))) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  utmi_line_state_t line_state_i,
  input  logic             rx_active_i,
  input  logic             wake_en_i,
  input  logic             wake_req_i,
  output utmi_op_mode_t    op_mode_o,
  output logic             suspend_m_o,
  output logic             tx_k_o,
  output logic             bus_reset_o,
  output logic             bus_reset_start_o,
  output logic             suspended_o,
  output logic             resume_done_o
);

  localparam logic [CNT_W-1:0] C_RST      = CNT_W'(RST_DET_CYC);
  localparam logic [CNT_W-1:0] C_SUSP     = CNT_W'(SUSP_DET_CYC);
  localparam logic [CNT_W-1:0] C_HOLD     = CNT_W'(WAKE_HOLD_CYC);
  localparam logic [CNT_W-1:0] C_DRV_LAST = CNT_W'(WAKE_DRV_CYC - 1);

  usb_linectl_state_t r_state;
  usb_linectl_cls_t   r_cls;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   r_se0_cnt;
  logic               r_k_prev;
  logic               r_seen_se0;
  logic               r_wake_pend;

  usb_linectl_state_t w_nxt;
  usb_linectl_cls_t   w_cls;
  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_run;
  logic [CNT_W-1:0]   w_se0_run;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_is_se0;
  logic               w_is_k;
  logic               w_is_j;

  always_comb begin
    w_is_se0 = (line_state_i == UTMI_LS_SE0);
    w_is_k   = (line_state_i == UTMI_LS_K);
    w_is_j   = (line_state_i == UTMI_LS_J);

    w_cls = LC_CLS_NONE;
    if (w_is_se0)                  w_cls = LC_CLS_SE0;
    else if (w_is_j && !rx_active_i) w_cls = LC_CLS_IDLE;

    w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

    // NORMAL run length: restart at 1 on a new class, 0 on K/SE1/activity
    if (w_cls == LC_CLS_NONE)  w_run = '0;
    else if (w_cls == r_cls)   w_run = w_cnt_inc;
    else                       w_run = CNT_W'(1);

    // SE0 run used by SUSPEND/RESUME, where r_cnt times something else
    if (!w_is_se0)              w_se0_run = '0;
    else if (r_se0_cnt == '1)   w_se0_run = r_se0_cnt;
    else                        w_se0_run = r_se0_cnt + 1'b1;
  end

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      LC_NORMAL: begin
        w_cnt_nxt = w_run;
        if (w_cls == LC_CLS_SE0 && w_run == C_RST)        w_nxt = LC_BUS_RESET;
        else if (w_cls == LC_CLS_IDLE && w_run == C_SUSP) w_nxt = LC_SUSPEND;
      end
      LC_BUS_RESET: begin
        if (!w_is_se0) w_nxt = LC_NORMAL;
      end
      LC_SUSPEND: begin
        w_cnt_nxt = (r_cnt == C_HOLD) ? r_cnt : w_cnt_inc;
        if (w_se0_run == C_RST)                              w_nxt = LC_BUS_RESET;
        else if (w_is_k && r_k_prev)                         w_nxt = LC_RESUME;
        else if (r_wake_pend && wake_en_i && r_cnt == C_HOLD) w_nxt = LC_WAKE_DRIVE;
      end
      LC_WAKE_DRIVE: begin
        w_cnt_nxt = w_cnt_inc;
        if (r_cnt == C_DRV_LAST) w_nxt = LC_RESUME;
      end
      LC_RESUME: begin
        if (w_se0_run == C_RST)          w_nxt = LC_BUS_RESET;
        else if (r_seen_se0 && w_is_j)   w_nxt = LC_NORMAL;
      end
      default: w_nxt = LC_NORMAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= LC_NORMAL;
      r_cls             <= LC_CLS_NONE;
      r_cnt             <= '0;
      r_se0_cnt         <= '0;
      r_k_prev          <= 1'b0;
      r_seen_se0        <= 1'b0;
      r_wake_pend       <= 1'b0;
      op_mode_o         <= UTMI_OM_NORMAL;
      suspend_m_o       <= 1'b1;
      tx_k_o            <= 1'b0;
      bus_reset_o       <= 1'b0;
      bus_reset_start_o <= 1'b0;
      suspended_o       <= 1'b0;
      resume_done_o     <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) begin
        r_cls      <= LC_CLS_NONE;
        r_cnt      <= '0;
        r_se0_cnt  <= '0;
        r_k_prev   <= 1'b0;
        r_seen_se0 <= 1'b0;
      end else begin
        r_cls      <= w_cls;
        r_cnt      <= w_cnt_nxt;
        r_se0_cnt  <= w_se0_run;
        r_k_prev   <= w_is_k;
        r_seen_se0 <= r_seen_se0 | w_is_se0;
      end
      // Wake request only latches while staying in SUSPEND
      r_wake_pend <= (r_state == LC_SUSPEND) && (w_nxt == LC_SUSPEND) &&
                     (r_wake_pend || (wake_req_i && wake_en_i));

      op_mode_o         <= (w_nxt == LC_WAKE_DRIVE) ? UTMI_OM_DISABLE : UTMI_OM_NORMAL;
      suspend_m_o       <= (w_nxt != LC_SUSPEND);
      tx_k_o            <= (w_nxt == LC_WAKE_DRIVE);
      bus_reset_o       <= (w_nxt == LC_BUS_RESET);
      bus_reset_start_o <= (w_nxt == LC_BUS_RESET) && (r_state != LC_BUS_RESET);
      suspended_o       <= (w_nxt == LC_SUSPEND);
      resume_done_o     <= (r_state == LC_RESUME) && (w_nxt == LC_NORMAL);
    end
  end

endmodule

// File: tb/tb_usb_utmi_linectl.sv
// Cycle-by-cycle scoreboard bench: every driven cycle queues the expected
// registered output vector, compared after the following clock edge.
module tb_usb_utmi_linectl;
  import usb_utmi_pkg::*;

  localparam int S_N = 0, S_BR = 1, S_SU = 2, S_WD = 3, S_RE = 4;

  logic             clk = 1'b0;
  logic             rst;
  utmi_line_state_t line_state;
  logic             rx_active, wake_en, wake_req;
  utmi_op_mode_t    op_mode;
  logic             suspend_m, tx_k, bus_reset, bus_reset_start, suspended, resume_done;

  usb_utmi_linectl #(
    .RST_DET_CYC(8), .SUSP_DET_CYC(20), .WAKE_HOLD_CYC(30), .WAKE_DRV_CYC(10)
  ) dut (
    .clk(clk), .rst(rst), .line_state_i(line_state), .rx_active_i(rx_active),
    .wake_en_i(wake_en), .wake_req_i(wake_req), .op_mode_o(op_mode),
    .suspend_m_o(suspend_m), .tx_k_o(tx_k), .bus_reset_o(bus_reset),
    .bus_reset_start_o(bus_reset_start), .suspended_o(suspended),
    .resume_done_o(resume_done)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [7:0] v; } exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;

  wire [7:0] dout = {op_mode, suspend_m, tx_k, bus_reset, bus_reset_start, suspended, resume_done};

  // {op_mode, suspend_m, tx_k, bus_reset, bus_reset_start, suspended, resume_done}
  function automatic logic [7:0] ev(int st, bit sp, bit dn);
    case (st)
      S_BR:    return {UTMI_OM_NORMAL,  1'b1, 1'b0, 1'b1, sp, 1'b0, dn};
      S_SU:    return {UTMI_OM_NORMAL,  1'b0, 1'b0, 1'b0, sp, 1'b1, dn};
      S_WD:    return {UTMI_OM_DISABLE, 1'b1, 1'b1, 1'b0, sp, 1'b0, dn};
      default: return {UTMI_OM_NORMAL,  1'b1, 1'b0, 1'b0, sp, 1'b0, dn};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step(input string tag, input utmi_line_state_t ls, input bit rx,
                      input bit wrq, input int st, input bit sp = 0, input bit dn = 0);
    exp_t e;
    sb.push_back('{tag, ev(st, sp, dn)});
    line_state = ls;
    rx_active  = rx;
    wake_req   = wrq;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, dout, e.v);
  endtask

  task automatic run(input string tag, input int n, input utmi_line_state_t ls,
                     input bit rx, input bit wrq, input int st);
    for (int i = 0; i < n; i++) step(tag, ls, rx, wrq, st);
  endtask

  initial begin
    rst = 1'b1; line_state = UTMI_LS_K; rx_active = 1'b0; wake_en = 1'b0; wake_req = 1'b0;
    @(posedge clk);
    step("reset", UTMI_LS_K, 0, 0, S_N);
    rst = 1'b0;
    step("post_reset", UTMI_LS_K, 0, 0, S_N);

    // Bus reset qualification
    run("se0_7", 7, UTMI_LS_SE0, 0, 0, S_N);
    step("se0_7_end", UTMI_LS_J, 1, 0, S_N);
    run("se0_8", 7, UTMI_LS_SE0, 0, 0, S_N);
    step("br_start", UTMI_LS_SE0, 0, 0, S_BR, 1);
    run("br_hold", 3, UTMI_LS_SE0, 0, 0, S_BR);
    step("br_exit", UTMI_LS_J, 1, 0, S_N);

    // Idle J broken by activity, then a clean 20-cycle idle
    run("idle_a", 9, UTMI_LS_J, 0, 0, S_N);
    step("idle_act", UTMI_LS_J, 1, 0, S_N);
    run("idle_b", 9, UTMI_LS_J, 0, 0, S_N);
    step("sep", UTMI_LS_K, 0, 0, S_N);
    run("idle_19", 19, UTMI_LS_J, 0, 0, S_N);
    step("susp_entry", UTMI_LS_J, 0, 0, S_SU);

    // Host resume with K glitch filtering
    step("k_glitch", UTMI_LS_K, 0, 0, S_SU);
    step("k_glitch_j", UTMI_LS_J, 0, 0, S_SU);
    step("k1", UTMI_LS_K, 0, 0, S_SU);
    step("k2_resume", UTMI_LS_K, 0, 0, S_RE);
    run("eor_se0", 2, UTMI_LS_SE0, 0, 0, S_RE);
    step("resume_done", UTMI_LS_J, 0, 0, S_N, 0, 1);
    step("resume_done_end", UTMI_LS_K, 0, 0, S_N);

    // Remote wakeup: request at suspend cycle 5, WAKE_DRIVE once cnt hits 30
    wake_en = 1'b1;
    run("w_idle", 19, UTMI_LS_J, 0, 0, S_N);
    step("w_susp", UTMI_LS_J, 0, 0, S_SU);
    for (int k = 1; k <= 30; k++) step("w_hold", UTMI_LS_J, 0, (k == 5), S_SU);
    step("wd_entry", UTMI_LS_J, 0, 0, S_WD);
    run("wd_hold", 9, UTMI_LS_K, 0, 0, S_WD);
    step("wd_to_resume", UTMI_LS_K, 0, 0, S_RE);
    step("host_k", UTMI_LS_K, 0, 0, S_RE);
    run("w_eor_se0", 2, UTMI_LS_SE0, 0, 0, S_RE);
    step("w_done", UTMI_LS_J, 0, 0, S_N, 0, 1);
    step("w_done_end", UTMI_LS_K, 0, 0, S_N);

    // Request seen only while NORMAL must not arm wakeup
    run("nreq_idle", 19, UTMI_LS_J, 0, 1, S_N);
    step("nreq_susp", UTMI_LS_J, 0, 1, S_SU);
    run("nreq_hold", 35, UTMI_LS_J, 0, 0, S_SU);

    // Wakeup disabled: request ignored, then bus reset out of SUSPEND
    wake_en = 1'b0;
    run("noen_hold", 40, UTMI_LS_J, 0, 1, S_SU);
    run("su_se0", 7, UTMI_LS_SE0, 0, 0, S_SU);
    step("su_br", UTMI_LS_SE0, 0, 0, S_BR, 1);
    step("su_br_exit", UTMI_LS_J, 1, 0, S_N);

    // Reset in the middle of WAKE_DRIVE
    wake_en = 1'b1;
    run("r_idle", 19, UTMI_LS_J, 0, 0, S_N);
    step("r_susp", UTMI_LS_J, 0, 0, S_SU);
    step("r_req", UTMI_LS_J, 0, 1, S_SU);
    run("r_hold", 29, UTMI_LS_J, 0, 0, S_SU);
    step("r_wd", UTMI_LS_J, 0, 0, S_WD);
    run("r_wd_hold", 2, UTMI_LS_K, 0, 0, S_WD);
    rst = 1'b1;
    step("rst_in_wd", UTMI_LS_K, 0, 0, S_N);
    rst = 1'b0;
    run("post_rst_se0", 7, UTMI_LS_SE0, 0, 0, S_N);
    step("post_rst_br", UTMI_LS_SE0, 0, 0, S_BR, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
